// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared encodings and helpers for the multiply/divide unit
package mdu_pkg;

  localparam int MDU_ITER = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FINISH
  } state_e;

  function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (32'd0 - v) : v;
  endfunction

endpackage

// File: rtl/mdu_iter.sv
// rtl/mdu_iter.sv - unsigned shift-add / restoring-divide datapath, one step per cycle
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load_i,
  input  logic              step_i,
  input  logic              is_div_i,
  input  logic [XLEN-1:0]   a_i,
  input  logic [XLEN-1:0]   b_i,
  output logic [5:0]        cnt_o,
  output logic [2*XLEN-1:0] res_o
);

  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opb_q;
  logic              is_div_q;
  logic [5:0]        cnt_q;
  logic [XLEN:0]     sum;
  logic [XLEN:0]     rem_sh;
  logic [XLEN-1:0]   diff;

  // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
  always_comb begin
    sum    = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    rem_sh = acc_q[2*XLEN-1:XLEN-1];
    diff   = rem_sh[XLEN-1:0] - opb_q;
    acc_d  = {sum, acc_q[XLEN-1:1]};
    if (is_div_q) begin
      if (rem_sh >= {1'b0, opb_q}) begin
        acc_d = {diff, acc_q[XLEN-2:0], 1'b1};
      end else begin
        acc_d = {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      acc_q    <= '0;
      opb_q    <= '0;
      is_div_q <= 1'b0;
      cnt_q    <= '0;
    end else if (load_i) begin
      acc_q    <= {{XLEN{1'b0}}, a_i};
      opb_q    <= b_i;
      is_div_q <= is_div_i;
      cnt_q    <= '0;
    end else if (step_i) begin
      acc_q    <= acc_d;
      cnt_q    <= cnt_q + 6'd1;
    end
  end

  assign cnt_o = cnt_q;
  assign res_o = acc_d;

endmodule

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative MULT/MULTU/DIV/DIVU unit with HI/LO result registers
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] in_s1,
  input  logic [XLEN-1:0] in_s2,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo,
  output logic            div_zero
);

  state_e            state_q, state_d;
  logic              load, last;
  logic              is_signed_in, is_div_in;
  logic              is_div_q, neg_q, rem_neg_q, zero_q;
  logic [XLEN-1:0]   s1_q;
  logic [XLEN-1:0]   hi_q, lo_q, hi_d, lo_d;
  logic              div_zero_q;
  logic [5:0]        cnt;
  logic [2*XLEN-1:0] res, prod;

  assign is_signed_in = (op_e'(op) == OP_MULT) || (op_e'(op) == OP_DIV);
  assign is_div_in    = op[1];

  mdu_iter #(.XLEN(XLEN)) u_iter (
    .clock    (clock),
    .reset    (reset),
    .load_i   (load),
    .step_i   (state_q == RUN),
    .is_div_i (is_div_in),
    .a_i      (mag32(in_s1, is_signed_in)),
    .b_i      (mag32(in_s2, is_signed_in)),
    .cnt_o    (cnt),
    .res_o    (res)
  );

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    last    = (state_q == RUN) && (cnt == 6'(MDU_ITER - 1));
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          load    = 1'b1;
        end
      end
      RUN: begin
        if (last) state_d = FINISH;
      end
      FINISH: begin
        if (start) begin
          state_d = RUN;
          load    = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Sign fix-up applied to the final step's result as it is written to HI/LO
  always_comb begin
    prod = neg_q ? ('0 - res) : res;
    hi_d = prod[2*XLEN-1:XLEN];
    lo_d = prod[XLEN-1:0];
    if (is_div_q) begin
      if (zero_q) begin
        hi_d = s1_q;
        lo_d = '1;
      end else begin
        hi_d = rem_neg_q ? ('0 - res[2*XLEN-1:XLEN]) : res[2*XLEN-1:XLEN];
        lo_d = neg_q ? ('0 - res[XLEN-1:0]) : res[XLEN-1:0];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      is_div_q   <= 1'b0;
      neg_q      <= 1'b0;
      rem_neg_q  <= 1'b0;
      zero_q     <= 1'b0;
      s1_q       <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      div_zero_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load) begin
        is_div_q  <= is_div_in;
        neg_q     <= is_signed_in && (in_s1[XLEN-1] ^ in_s2[XLEN-1]);
        rem_neg_q <= is_signed_in && in_s1[XLEN-1];
        zero_q    <= (in_s2 == '0);
        s1_q      <= in_s1;
      end
      if (last) begin
        hi_q       <= hi_d;
        lo_q       <= lo_d;
        div_zero_q <= is_div_q && zero_q;
      end
    end
  end

  assign busy     = (state_q == RUN);
  assign done     = (state_q == FINISH);
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign div_zero = div_zero_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - scoreboard bench for mult_div_unit
module tb_mult_div_unit;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] in_s1, in_s2;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;

  exp_t exp_q[$];
  int   vec_cnt = 0;
  int   err_cnt = 0;

  mult_div_unit #(.XLEN(32)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .in_s1    (in_s1),
    .in_s2    (in_s2),
    .busy     (busy),
    .done     (done),
    .hi       (hi),
    .lo       (lo),
    .div_zero (div_zero)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    longint      pa, pb;
    logic [63:0] p;
    int          sa, sd;
    e.dz = 1'b0;
    e.hi = '0;
    e.lo = '0;
    if (o == 2'b00) begin
      pa = longint'($signed(a));
      pb = longint'($signed(b));
      p  = pa * pb;
      e.hi = p[63:32];
      e.lo = p[31:0];
    end else if (o == 2'b01) begin
      p  = {32'd0, a} * {32'd0, b};
      e.hi = p[63:32];
      e.lo = p[31:0];
    end else if (b == 32'd0) begin
      e.hi = a;
      e.lo = 32'hFFFF_FFFF;
      e.dz = 1'b1;
    end else if (o == 2'b11) begin
      e.lo = a / b;
      e.hi = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      e.lo = 32'h8000_0000;
      e.hi = 32'd0;
    end else begin
      sa = $signed(a);
      sd = $signed(b);
      e.lo = sa / sd;
      e.hi = sa % sd;
    end
    return e;
  endfunction

  // Drive a start for one cycle at a falling edge, then scramble inputs.
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    op    = o;
    in_s1 = a;
    in_s2 = b;
    exp_q.push_back(model(o, a, b));
    @(negedge clock);
    start = 1'b0;
    op    = 2'($urandom);
    in_s1 = $urandom;
    in_s2 = $urandom;
  endtask

  task automatic wait_done(input int lat0, input int busy0);
    int          lat  = lat0;
    int          bcnt = busy0;
    int          chg  = 0;
    logic [31:0] h0   = hi;
    logic [31:0] l0   = lo;
    exp_t        e;
    while (!done && lat < 40) begin
      if (busy) bcnt++;
      if (hi !== h0 || lo !== l0) chg++;
      @(negedge clock);
      lat++;
    end
    check_eq("done_seen", done, 1);
    check_eq("latency", lat, 33);
    check_eq("busy_cycles", bcnt, 32);
    check_eq("hilo_hold_in_run", chg, 0);
    check_eq("busy_in_finish", busy, 0);
    check_eq("sb_nonempty", exp_q.size() > 0, 1);
    if (done && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_eq("hi", hi, e.hi);
      check_eq("lo", lo, e.lo);
      check_eq("div_zero", div_zero, e.dz);
    end
  endtask

  task automatic after_done();
    @(negedge clock);
    check_eq("done_pulse", done, 0);
  endtask

  initial begin
    int dcnt;
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    reset = 1'b1;
    start = 1'b0;
    op    = 2'b00;
    in_s1 = '0;
    in_s2 = '0;
    repeat (3) @(negedge clock);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_hi", hi, 0);
    check_eq("rst_lo", lo, 0);
    check_eq("rst_dz", div_zero, 0);

    start = 1'b1;
    in_s1 = 32'd5;
    in_s2 = 32'd6;
    @(negedge clock);
    reset = 1'b0;
    start = 1'b0;
    check_eq("start_in_reset_ignored", busy, 0);
    @(negedge clock);

    issue(2'b00, 32'hFFFF_FFFD, 32'd7);
    wait_done(1, 0);
    after_done();

    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(1, 0);
    after_done();

    issue(2'b10, 32'hFFFF_FFF9, 32'd2);
    wait_done(1, 0);
    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(1, 0);
    after_done();

    issue(2'b11, 32'd100, 32'd0);
    wait_done(1, 0);
    after_done();
    issue(2'b01, 32'd3, 32'd4);
    wait_done(1, 0);
    after_done();

    issue(2'b10, 32'hFFFF_FF00, 32'd0);
    wait_done(1, 0);
    after_done();

    issue(2'b01, 32'h0001_2345, 32'h0000_6789);
    start = 1'b1;
    op    = 2'b10;
    in_s1 = 32'hDEAD_BEEF;
    in_s2 = 32'd3;
    @(negedge clock);
    start = 1'b0;
    wait_done(2, 1);
    after_done();

    for (int i = 0; i < 8; i++) begin
      ro = 2'($urandom);
      ra = (i == 0) ? 32'd1 : $urandom;
      rb = (i == 1) ? 32'd0 : ((i == 2) ? 32'd1 : $urandom);
      if (ro[1] && i > 2) rb = rb >> $urandom_range(0, 28);
      issue(ro, ra, rb);
      wait_done(1, 0);
      after_done();
    end

    issue(2'b00, 32'd12345, 32'hFFFF_FFFD);
    repeat (9) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check_eq("abort_busy", busy, 0);
    check_eq("abort_hi", hi, 0);
    check_eq("abort_lo", lo, 0);
    reset = 1'b0;
    exp_q.delete();
    dcnt = 0;
    repeat (40) begin
      if (done) dcnt++;
      @(negedge clock);
    end
    check_eq("no_done_after_abort", dcnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
